// File: rtl/jtag_l2_arb_pkg.sv
// Shared types and constants for the JTAG/core L2 SRAM arbiter.
package jtag_l2_arb_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int MST_JTAG    = 0;
  localparam int MST_CORE    = 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin pick: a lone requester wins, a tie goes to prio.
module rr_pick2
  import jtag_l2_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   prio,
  output logic [NUM_MASTERS-1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req[MST_JTAG] && req[MST_CORE]) begin
      gnt[MST_CORE] = prio;
      gnt[MST_JTAG] = ~prio;
    end else if (req[MST_JTAG]) begin
      gnt[MST_JTAG] = 1'b1;
    end else if (req[MST_CORE]) begin
      gnt[MST_CORE] = 1'b1;
    end
  end

endmodule

// File: rtl/jtag_l2_arbiter.sv
// Arbitrates the JTAG bridge and the core onto one single-port L2 SRAM,
// with burst locking, an idle-timeout release and a one-cycle response path.
module jtag_l2_arbiter
  import jtag_l2_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_MASTERS-1:0]       m_req_i,
  input  logic [NUM_MASTERS-1:0]       m_we_i,
  input  logic [NUM_MASTERS-1:0][31:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0][31:0] m_wdata_i,
  input  logic [NUM_MASTERS-1:0][3:0]  m_be_i,
  input  logic [NUM_MASTERS-1:0][7:0]  m_len_i,
  output logic [NUM_MASTERS-1:0]       m_gnt_o,
  output logic [NUM_MASTERS-1:0]       m_rvalid_o,
  output logic [31:0]                  m_rdata_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [31:0]                  mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  output logic [3:0]                   mem_be_o,
  input  logic [31:0]                  mem_rdata_i,
  output logic                         err_timeout_o
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  arb_state_e             state_q, state_d;
  logic                   owner_q, owner_d;
  logic [7:0]             beats_left_q, beats_left_d;
  logic [31:0]            next_addr_q, next_addr_d;
  logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
  logic                   rr_prio_q, rr_prio_d;
  logic [NUM_MASTERS-1:0] rvalid_q;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [NUM_MASTERS-1:0] gnt_raw;
  logic [31:0]            addr_raw;
  logic                   err_raw;
  logic                   winner;
  logic                   sel;

  rr_pick2 u_pick (
    .req  (m_req_i),
    .prio (rr_prio_q),
    .gnt  (pick_gnt)
  );

  assign winner = pick_gnt[MST_CORE];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    beats_left_d = beats_left_q;
    next_addr_d  = next_addr_q;
    idle_cnt_d   = idle_cnt_q;
    rr_prio_d    = rr_prio_q;
    gnt_raw      = '0;
    addr_raw     = '0;
    err_raw      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt_raw = pick_gnt;
        if (|pick_gnt) begin
          addr_raw = m_addr_i[winner];
          if (m_len_i[winner] == 8'd0) begin
            rr_prio_d = ~winner;
          end else begin
            state_d      = ST_LOCKED;
            owner_d      = winner;
            beats_left_d = m_len_i[winner];
            next_addr_d  = m_addr_i[winner] + 32'd4;
            idle_cnt_d   = '0;
          end
        end
      end
      ST_LOCKED: begin
        // An owner request always wins over an expiring idle count.
        if (m_req_i[owner_q]) begin
          gnt_raw[owner_q] = 1'b1;
          addr_raw         = next_addr_q;
          next_addr_d      = next_addr_q + 32'd4;
          beats_left_d     = beats_left_q - 8'd1;
          idle_cnt_d       = '0;
          if (beats_left_q == 8'd1) begin
            state_d   = ST_IDLE;
            rr_prio_d = ~owner_q;
          end
        end else if (idle_cnt_q == IDLE_LAST) begin
          err_raw    = 1'b1;
          state_d    = ST_IDLE;
          rr_prio_d  = ~owner_q;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset forces every output low at once, even with requests pending.
  always_comb begin
    m_gnt_o       = rst_i ? '0 : gnt_raw;
    err_timeout_o = err_raw & ~rst_i;
    sel           = m_gnt_o[MST_CORE];
    mem_req_o     = |m_gnt_o;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    mem_be_o      = '0;
    if (mem_req_o) begin
      mem_we_o    = m_we_i[sel];
      mem_addr_o  = addr_raw;
      mem_wdata_o = m_wdata_i[sel];
      mem_be_o    = m_be_i[sel];
    end
  end

  assign m_rvalid_o = rvalid_q;
  assign m_rdata_o  = (|rvalid_q) ? mem_rdata_i : 32'd0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      beats_left_q <= '0;
      next_addr_q  <= '0;
      idle_cnt_q   <= '0;
      rr_prio_q    <= 1'b0;
      rvalid_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      beats_left_q <= beats_left_d;
      next_addr_q  <= next_addr_d;
      idle_cnt_q   <= idle_cnt_d;
      rr_prio_q    <= rr_prio_d;
      rvalid_q     <= m_gnt_o;
    end
  end

endmodule

// File: tb/tb_jtag_l2_arbiter.sv
// Self-checking bench: per-cycle behavioural model plus directed scenarios
// with hand-computed literal expectations.
module tb_jtag_l2_arbiter;

  localparam int TIMEOUT = 16;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [1:0]        m_req_i = '0;
  logic [1:0]        m_we_i = '0;
  logic [1:0][31:0]  m_addr_i = '0;
  logic [1:0][31:0]  m_wdata_i = '0;
  logic [1:0][3:0]   m_be_i = '0;
  logic [1:0][7:0]   m_len_i = '0;
  logic [1:0]        m_gnt_o;
  logic [1:0]        m_rvalid_o;
  logic [31:0]       m_rdata_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [31:0]       mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [3:0]        mem_be_o;
  logic [31:0]       mem_rdata_i = '0;
  logic              err_timeout_o;

  int errors = 0;
  int checks = 0;

  jtag_l2_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .m_req_i       (m_req_i),
    .m_we_i        (m_we_i),
    .m_addr_i      (m_addr_i),
    .m_wdata_i     (m_wdata_i),
    .m_be_i        (m_be_i),
    .m_len_i       (m_len_i),
    .m_gnt_o       (m_gnt_o),
    .m_rvalid_o    (m_rvalid_o),
    .m_rdata_o     (m_rdata_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_be_o      (mem_be_o),
    .mem_rdata_i   (mem_rdata_i),
    .err_timeout_o (err_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM: one-cycle read latency, byte-enabled writes, zero on non-read cycles.
  logic [31:0] sram [logic [31:0]];

  function automatic logic [31:0] sram_rd(input logic [31:0] a);
    if (sram.exists(a)) return sram[a];
    return 32'd0;
  endfunction

  always @(posedge clk_i) begin
    logic [31:0] w;
    if (mem_req_o && mem_we_o) begin
      w = sram_rd(mem_addr_o);
      for (int b = 0; b < 4; b++)
        if (mem_be_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
      sram[mem_addr_o] = w;
      mem_rdata_i <= 32'd0;
    end else if (mem_req_o) begin
      mem_rdata_i <= sram_rd(mem_addr_o);
    end else begin
      mem_rdata_i <= 32'd0;
    end
  end

  // Behavioural model: burst bookkeeping in plain integers.
  bit          in_burst = 0;
  int          burst_owner = 0;
  int          beats_remaining = 0;
  logic [31:0] burst_addr = '0;
  int          idle_run = 0;
  int          favoured = 0;
  logic [1:0]  pend_gnt = '0;
  logic [31:0] pend_rdata = '0;

  always @(negedge clk_i) begin
    int gm;
    logic [1:0]  e_gnt;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;
    logic        e_we, e_err;
    logic [1:0]  e_rvalid;
    gm = -1;
    e_gnt = '0; e_addr = '0; e_wdata = '0; e_be = '0; e_we = 1'b0; e_err = 1'b0;
    e_rvalid = '0; e_rdata = '0;
    if (rst_i) begin
      in_burst = 0; burst_owner = 0; beats_remaining = 0; burst_addr = '0;
      idle_run = 0; favoured = 0; pend_gnt = '0; pend_rdata = '0;
    end else begin
      if (!in_burst) begin
        if (m_req_i == 2'b11) gm = favoured;
        else if (m_req_i[0]) gm = 0;
        else if (m_req_i[1]) gm = 1;
        if (gm >= 0) begin
          e_addr = m_addr_i[gm];
          if (m_len_i[gm] == 0) begin
            favoured = 1 - gm;
          end else begin
            in_burst = 1; burst_owner = gm; beats_remaining = m_len_i[gm];
            burst_addr = m_addr_i[gm] + 32'd4; idle_run = 0;
          end
        end
      end else if (m_req_i[burst_owner]) begin
        gm = burst_owner;
        e_addr = burst_addr;
        burst_addr = burst_addr + 32'd4;
        beats_remaining--;
        idle_run = 0;
        if (beats_remaining == 0) begin
          in_burst = 0;
          favoured = 1 - burst_owner;
        end
      end else begin
        idle_run++;
        if (idle_run == TIMEOUT) begin
          e_err = 1'b1;
          in_burst = 0;
          favoured = 1 - burst_owner;
        end
      end
      if (gm >= 0) begin
        e_gnt[gm] = 1'b1;
        e_we = m_we_i[gm];
        e_wdata = m_wdata_i[gm];
        e_be = m_be_i[gm];
      end
      e_rvalid = pend_gnt;
      e_rdata  = (pend_gnt != 0) ? pend_rdata : 32'd0;
      pend_gnt = e_gnt;
      pend_rdata = (gm >= 0 && !m_we_i[gm]) ? sram_rd(e_addr) : 32'd0;
    end
    chk("model gnt", {30'd0, m_gnt_o}, {30'd0, e_gnt});
    chk("model mem_req", {31'd0, mem_req_o}, {31'd0, |e_gnt});
    chk("model mem_addr", mem_addr_o, e_addr);
    chk("model mem_we", {31'd0, mem_we_o}, {31'd0, e_we});
    chk("model mem_wdata", mem_wdata_o, e_wdata);
    chk("model mem_be", {28'd0, mem_be_o}, {28'd0, e_be});
    chk("model rvalid", {30'd0, m_rvalid_o}, {30'd0, e_rvalid});
    chk("model rdata", m_rdata_o, e_rdata);
    chk("model err_timeout", {31'd0, err_timeout_o}, {31'd0, e_err});
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] req);
    m_req_i = req;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, act, exp);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    m_req_i = '0; m_we_i = '0; m_addr_i = '0; m_wdata_i = '0; m_be_i = '0; m_len_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tick();
    @(negedge clk_i);
    checkOutput("reset gnt", {30'd0, m_gnt_o}, 32'd0);
    checkOutput("reset rvalid", {30'd0, m_rvalid_o}, 32'd0);
    checkOutput("reset mem_req", {31'd0, mem_req_o}, 32'd0);
    do_reset();

    // JTAG single write then single read of address 0
    m_we_i[0] = 1'b1; m_addr_i[0] = 32'h0; m_wdata_i[0] = 32'hABBAABBA;
    m_be_i[0] = 4'hF; m_len_i[0] = 8'd0;
    applyStimulus(2'b01);
    @(negedge clk_i);
    checkOutput("wr gnt", {30'd0, m_gnt_o}, 32'd1);
    checkOutput("wr mem_wdata", mem_wdata_o, 32'hABBAABBA);
    tick();
    m_we_i[0] = 1'b0;
    @(negedge clk_i);
    checkOutput("rd gnt", {30'd0, m_gnt_o}, 32'd1);
    tick();
    applyStimulus(2'b00);
    @(negedge clk_i);
    checkOutput("rd rvalid", {30'd0, m_rvalid_o}, 32'd1);
    checkOutput("rd rdata", m_rdata_o, 32'hABBAABBA);
    tick();

    // Both request single beats from reset: JTAG, core, JTAG
    do_reset();
    m_addr_i[0] = 32'h8; m_addr_i[1] = 32'hC;
    applyStimulus(2'b11);
    @(negedge clk_i);
    checkOutput("rr gnt 1", {30'd0, m_gnt_o}, 32'd1);
    tick();
    @(negedge clk_i);
    checkOutput("rr gnt 2", {30'd0, m_gnt_o}, 32'd2);
    tick();
    @(negedge clk_i);
    checkOutput("rr gnt 3", {30'd0, m_gnt_o}, 32'd1);
    tick();
    applyStimulus(2'b00);

    // Core 4-beat burst at 0x100 with JTAG requesting throughout
    do_reset();
    m_we_i[1] = 1'b1; m_addr_i[1] = 32'h100; m_wdata_i[1] = 32'h11223344;
    m_be_i[1] = 4'hF; m_len_i[1] = 8'd3;
    m_addr_i[0] = 32'h40; m_len_i[0] = 8'd0;
    applyStimulus(2'b10);
    @(negedge clk_i);
    checkOutput("burst gnt 0", {30'd0, m_gnt_o}, 32'd2);
    checkOutput("burst addr 0", mem_addr_o, 32'h100);
    tick();
    applyStimulus(2'b11);
    m_addr_i[1] = 32'hDEAD0000;
    for (int i = 1; i < 4; i++) begin
      logic [31:0] exp_a;
      exp_a = 32'h100 + 32'(4 * i);
      @(negedge clk_i);
      checkOutput("burst gnt", {30'd0, m_gnt_o}, 32'd2);
      checkOutput("burst addr", mem_addr_o, exp_a);
      tick();
    end
    @(negedge clk_i);
    checkOutput("after burst gnt", {30'd0, m_gnt_o}, 32'd1);
    checkOutput("after burst addr", mem_addr_o, 32'h40);
    tick();
    applyStimulus(2'b00);

    // Burst across the top of the address space
    do_reset();
    m_we_i[0] = 1'b0; m_addr_i[0] = 32'hFFFF_FFFC; m_len_i[0] = 8'd1;
    applyStimulus(2'b01);
    @(negedge clk_i);
    checkOutput("wrap addr 0", mem_addr_o, 32'hFFFF_FFFC);
    tick();
    m_addr_i[0] = 32'h5555_0000;
    @(negedge clk_i);
    checkOutput("wrap addr 1", mem_addr_o, 32'h0000_0000);
    checkOutput("wrap gnt 1", {30'd0, m_gnt_o}, 32'd1);
    tick();
    applyStimulus(2'b00);

    // JTAG len-7 burst abandoned after two beats: timeout, then core
    do_reset();
    m_we_i = 2'b00; m_addr_i[0] = 32'h200; m_len_i[0] = 8'd7;
    m_addr_i[1] = 32'h300; m_len_i[1] = 8'd0;
    applyStimulus(2'b11);
    @(negedge clk_i);
    checkOutput("to beat 0", {30'd0, m_gnt_o}, 32'd1);
    tick();
    @(negedge clk_i);
    checkOutput("to beat 1 addr", mem_addr_o, 32'h204);
    tick();
    applyStimulus(2'b10);
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(negedge clk_i);
      checkOutput("to idle gnt", {30'd0, m_gnt_o}, 32'd0);
      checkOutput("to idle err", {31'd0, err_timeout_o}, (i == TIMEOUT) ? 32'd1 : 32'd0);
      tick();
    end
    @(negedge clk_i);
    checkOutput("to core gnt", {30'd0, m_gnt_o}, 32'd2);
    checkOutput("to err cleared", {31'd0, err_timeout_o}, 32'd0);
    tick();
    applyStimulus(2'b00);

    // Reset in the middle of a core burst
    do_reset();
    m_we_i[1] = 1'b1; m_addr_i[1] = 32'h300; m_wdata_i[1] = 32'hCAFEF00D;
    m_be_i[1] = 4'hF; m_len_i[1] = 8'd5;
    m_we_i[0] = 1'b0; m_addr_i[0] = 32'h10; m_len_i[0] = 8'd0;
    applyStimulus(2'b10);
    @(negedge clk_i);
    checkOutput("rst burst gnt 0", {30'd0, m_gnt_o}, 32'd2);
    tick();
    @(negedge clk_i);
    checkOutput("rst burst gnt 1", {30'd0, m_gnt_o}, 32'd2);
    tick();
    rst_i = 1'b1;
    applyStimulus(2'b11);
    @(negedge clk_i);
    checkOutput("rst gnt", {30'd0, m_gnt_o}, 32'd0);
    checkOutput("rst mem_req", {31'd0, mem_req_o}, 32'd0);
    checkOutput("rst mem_addr", mem_addr_o, 32'd0);
    checkOutput("rst mem_wdata", mem_wdata_o, 32'd0);
    checkOutput("rst rvalid", {30'd0, m_rvalid_o}, 32'd0);
    checkOutput("rst rdata", m_rdata_o, 32'd0);
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("post rst rvalid", {30'd0, m_rvalid_o}, 32'd0);
    checkOutput("post rst gnt", {30'd0, m_gnt_o}, 32'd1);
    tick();
    applyStimulus(2'b00);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
